// File: rtl/adder_accumulator.sv
// adder_accumulator: accumulates a run of num_terms operands through an
// N-bit ripple-carry adder, tracking a sticky carry-out overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new run (honoured in IDLE or DONE only)
//   num_terms  operand count for the run, latched on an accepted start
//   in_valid   in_data carries an operand
//   in_data    operand (N bits)
//   in_ready   operand accepted this cycle (high exactly in ACCUM)
//   acc_out    registered running sum mod 2^N
//   ovf        sticky carry-out flag for the current run
//   busy       high while in ACCUM
//   done       one-cycle pulse while in DONE
module adder_accumulator #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   num_terms,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] acc_out,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   term_cnt, term_cnt_next;
  logic [CNT_W-1:0]   num_terms_q, num_terms_next;
  logic [N-1:0]       acc_next;
  logic               ovf_next;

  logic [N-1:0]       sum_c;
  logic [N:0]         carry_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  // Ripple-carry adder, carry-in tied low; carry_c[N] is the carry-out.
  always_comb begin
    carry_c    = '0;
    sum_c      = '0;
    carry_c[0] = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_c[i]     = acc_out[i] ^ in_data[i] ^ carry_c[i];
      carry_c[i+1] = (acc_out[i] & in_data[i]) | (carry_c[i] & (acc_out[i] ^ in_data[i]));
    end
  end

  assign cnt_inc_c = term_cnt + CNT_W'(1);

  // Next-state and datapath next values.
  always_comb begin
    state_next     = state;
    acc_next       = acc_out;
    ovf_next       = ovf;
    term_cnt_next  = term_cnt;
    num_terms_next = num_terms_q;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          num_terms_next = num_terms;
          acc_next       = '0;
          ovf_next       = 1'b0;
          term_cnt_next  = '0;
          state_next     = (num_terms != '0) ? ACCUM : DONE;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_next      = sum_c;
          ovf_next      = ovf | carry_c[N];
          term_cnt_next = cnt_inc_c;
          if (cnt_inc_c == num_terms_q) begin
            state_next = DONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and status registers; status flags track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_out     <= '0;
      ovf         <= 1'b0;
      term_cnt    <= '0;
      num_terms_q <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      acc_out     <= acc_next;
      ovf         <= ovf_next;
      term_cnt    <= term_cnt_next;
      num_terms_q <= num_terms_next;
      in_ready    <= (state_next == ACCUM);
      busy        <= (state_next == ACCUM);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator (N=8): directed scenarios plus
// randomized runs against an arithmetic reference model.
module tb_adder_accumulator;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start;
  logic [7:0]   num_terms;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] acc_out;
  logic         ovf;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  int unsigned  m_acc;
  bit           m_ovf;
  logic [N-1:0] ops[$];

  adder_accumulator #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: running sum with wrap at 2^N; a wrap means a carry-out.
  task automatic model_add(input logic [N-1:0] x);
    m_acc = m_acc + 32'(x);
    if (m_acc >= (32'd1 << N)) begin
      m_ovf = 1'b1;
      m_acc = m_acc - (32'd1 << N);
    end
  endtask

  // Starts a run of n operands taken from ops, with random in_valid gaps.
  // Ends in the cycle following the final transfer (DONE).
  task automatic do_run(input int n, input int max_gap, input bit mid_start);
    int gap;
    start     = 1'b1;
    num_terms = 8'(n);
    in_valid  = 1'b0;
    step();
    start     = 1'b0;
    num_terms = 8'($urandom);
    m_acc     = 0;
    m_ovf     = 1'b0;
    chk("start_acc_clr", 32'(acc_out), 32'd0);
    chk("start_ovf_clr", 32'(ovf), 32'd0);
    chk("start_busy", 32'(busy), 32'(n != 0));
    chk("start_ready", 32'(in_ready), 32'(n != 0));
    chk("start_done", 32'(done), 32'(n == 0));
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = N'($urandom);
        start    = mid_start & 1'($urandom_range(1, 0));
        step();
        chk("gap_acc_hold", 32'(acc_out), m_acc);
        chk("gap_busy", 32'(busy), 32'd1);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = ops[i];
      chk("ready_pre_xfer", 32'(in_ready), 32'd1);
      step();
      model_add(ops[i]);
      chk("xfer_acc", 32'(acc_out), m_acc);
      chk("xfer_ovf", 32'(ovf), 32'(m_ovf));
      chk("xfer_done", 32'(done), 32'(i == n - 1));
      chk("xfer_busy", 32'(busy), 32'(i != n - 1));
    end
    in_valid = 1'b0;
  endtask

  // Leaves DONE without a new start, then checks values hold in IDLE.
  task automatic idle_out();
    start    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_acc_hold", 32'(acc_out), m_acc);
    chk("idle_ovf_hold", 32'(ovf), 32'(m_ovf));
    in_valid = 1'b1;
    in_data  = N'($urandom);
    step();
    in_valid = 1'b0;
    chk("idle_valid_ignored", 32'(acc_out), m_acc);
    chk("idle_valid_ovf", 32'(ovf), 32'(m_ovf));
  endtask

  initial begin
    start     = 1'b0;
    num_terms = 8'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    m_acc     = 0;
    m_ovf     = 1'b0;

    // Reset state before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    #10 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // 10+20+30
    ops = '{8'd10, 8'd20, 8'd30};
    do_run(3, 0, 1'b0);
    chk("sum60_acc", 32'(acc_out), 32'd60);
    chk("sum60_ovf", 32'(ovf), 32'd0);
    idle_out();

    // 200+100 wraps; then 1+1 clears ovf
    ops = '{8'd200, 8'd100};
    do_run(2, 0, 1'b0);
    chk("wrap_acc", 32'(acc_out), 32'd44);
    chk("wrap_ovf", 32'(ovf), 32'd1);
    idle_out();
    ops = '{8'd1, 8'd1};
    do_run(2, 0, 1'b0);
    chk("small_acc", 32'(acc_out), 32'd2);
    chk("small_ovf", 32'(ovf), 32'd0);
    idle_out();

    // Zero-term run
    do_run(0, 0, 1'b0);
    idle_out();

    // 4 x 0xFF with gaps and mid-run start pulses
    ops = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_run(4, 3, 1'b1);
    chk("ff4_acc", 32'(acc_out), 32'h0FC);
    chk("ff4_ovf", 32'(ovf), 32'd1);

    // Back-to-back run from DONE with start held high
    ops = '{8'd3, 8'd4};
    do_run(2, 1, 1'b0);
    chk("b2b_acc", 32'(acc_out), 32'd7);
    idle_out();

    // Async reset mid-run after 2 of 5 transfers
    start     = 1'b1;
    num_terms = 8'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_acc", 32'(acc_out), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", 32'(acc_out), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_done", 32'(done), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    ops = '{8'd5, 8'd6};
    do_run(2, 1, 1'b0);
    chk("after_rst_acc", 32'(acc_out), 32'd11);
    idle_out();

    // Randomized runs, some back-to-back
    for (int r = 0; r < 12; r++) begin
      int n;
      n = int'($urandom_range(6, 0));
      ops = {};
      for (int k = 0; k < n; k++) ops.push_back(N'($urandom));
      do_run(n, 2, 1'b1);
      if ($urandom_range(1, 0) == 1) idle_out();
    end
    idle_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 Parameter: N, default 8, operand and accumulator width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request a new accumulation run; sampled only in IDLE or DONE.
REQ-005 Port: num_terms  input  8  number of operands in the run; sampled on the accepted start.
REQ-006 Port: in_valid  input  1  in_data holds a valid operand.
REQ-007 Port: in_data  input  N  operand to add to the running sum.
REQ-008 Port: in_ready  output  1  block accepts an operand this cycle.
REQ-009 Port: acc_out  output  N  registered running sum.
REQ-010 Port: ovf  output  1  sticky flag; set if any addition in the run produced a carry-out.
REQ-011 Port: busy  output  1  high while in ACCUM.
REQ-012 Port: done  output  1  one-cycle pulse marking run completion.

Function
REQ-013 The block SHALL have three states: IDLE, ACCUM, DONE; encoding is free.
REQ-014 IDLE with start=1 SHALL latch num_terms, clear acc_out and ovf, and go to ACCUM (num_terms>0) or DONE (num_terms=0) on the next edge.
REQ-015 in_ready SHALL equal 1 exactly in ACCUM; busy SHALL equal in_ready.
REQ-016 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1; no other edge changes acc_out in ACCUM.
REQ-017 Per transfer: acc_out <= (acc_out + in_data) mod 2^N, computed by an N-bit ripple-carry adder with c_in tied to 0.
REQ-018 Per transfer: ovf <= ovf OR adder c_out; ovf SHALL never clear within a run.
REQ-019 An 8-bit term counter SHALL increment per transfer; the transfer that makes the count equal the latched num_terms SHALL move ACCUM -> DONE.
REQ-020 Latency: acc_out and ovf SHALL reflect a transfer on the edge that accepts it (visible the following cycle).
REQ-021 done SHALL be 1 only during the single cycle spent in DONE.
REQ-022 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL behave as IDLE with start=1 (back-to-back runs).
REQ-023 start in ACCUM SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-024 acc_out and ovf SHALL hold their final values in IDLE until the next accepted start.
REQ-025 in_valid may toggle arbitrarily; gaps SHALL stall the run without altering acc_out, ovf or the counter.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, acc_out=0, ovf=0, counter=0, latched num_terms=0, done=0, busy=0, in_ready=0.
REQ-027 Reset asserted mid-run SHALL discard the run; no done pulse SHALL follow reset release.
REQ-028 After rst_n rises, the first start SHALL be honoured on the first rising edge at which it is seen high.

Verification
REQ-029 N=8, start with num_terms=3, operands 10,20,30 back-to-back -> acc_out=60, ovf=0, done high exactly one cycle after third transfer.
REQ-030 num_terms=2, operands 200,100 -> acc_out=44, ovf=1; a following run of 1,1 -> acc_out=2, ovf=0.
REQ-031 start with num_terms=0 -> DONE next cycle, done pulse, acc_out=0, in_ready never high.
REQ-032 num_terms=4, operands 0xFF x4 with in_valid gaps of 0-3 cycles, start pulsed mid-run -> acc_out=0xFC, ovf=1, start ignored, counter unaffected by gaps.
REQ-033 rst_n low for a non-edge-aligned half-cycle after 2 of 5 transfers -> outputs zero without a clock edge; no done; new run of 5,6 afterwards -> acc_out=11.
REQ-034 start held high through DONE -> second run starts with no IDLE cycle; acc_out cleared at that edge.
